ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same PS2_CLK/PS2_DAT pair the keyboard receive path uses.
- Performs the PS/2 request-to-send sequence, shifts data, odd parity and stop on device-generated clocks, then checks the device ACK.
- While busy is high, the keyboard receive path ignores the bus.

---
 rtl/ps2_host_tx.sv | 188 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 command transmitter.
//
// Sends one command byte to the keyboard over the shared PS2_CLK/PS2_DAT
// pair: holds the clock low to inhibit the device, issues request-to-send,
// shifts eight data bits (LSB first), odd parity and stop on the
// device-generated clock, then samples the device ACK.
//
// Ports:
//   CLOCK_50   in   system clock (50 MHz)
//   reset      in   synchronous, active-high reset
//   cmd_data   in   command byte, latched on accept
//   cmd_valid  in   command present; accepted when cmd_ready is high
//   cmd_ready  out  idle and able to accept a command
//   busy       out  transfer in progress (through the done/error cycle)
//   tx_done    out  one-cycle pulse: byte sent and ACK received
//   tx_error   out  one-cycle pulse: timeout or missing ACK
//   PS2_CLK    io   open-drain clock: driven 0 or released
//   PS2_DAT    io   open-drain data: driven 0 or released
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    inout  wire logic  PS2_CLK,
    inout  wire logic  PS2_DAT
);

    // One counter serves both the inhibit period and the transfer timeout.
    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                      INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_WAIT_IDLE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state, state_n;
    logic [7:0]    data_q, data_n;
    logic          par_q, par_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [3:0]    bitn_q, bitn_n;
    logic          dat_bit_q, dat_bit_n;

    logic clk_meta, clk_sync, clk_sync_d;
    logic dat_meta, dat_sync;
    logic fall;
    logic clk_low, dat_low;

    // Two-flop synchronizers; the idle bus is high, so reset to 1.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_meta   <= 1'b1;
            clk_sync   <= 1'b1;
            clk_sync_d <= 1'b1;
            dat_meta   <= 1'b1;
            dat_sync   <= 1'b1;
        end else begin
            clk_meta   <= PS2_CLK;
            clk_sync   <= clk_meta;
            clk_sync_d <= clk_sync;
            dat_meta   <= PS2_DAT;
            dat_sync   <= dat_meta;
        end
    end

    assign fall = clk_sync_d & ~clk_sync;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= S_IDLE;
            data_q    <= '0;
            par_q     <= 1'b0;
            cnt_q     <= '0;
            bitn_q    <= '0;
            dat_bit_q <= 1'b1;
        end else begin
            state     <= state_n;
            data_q    <= data_n;
            par_q     <= par_n;
            cnt_q     <= cnt_n;
            bitn_q    <= bitn_n;
            dat_bit_q <= dat_bit_n;
        end
    end

    always_comb begin
        state_n   = state;
        data_n    = data_q;
        par_n     = par_q;
        cnt_n     = cnt_q;
        bitn_n    = bitn_q;
        dat_bit_n = dat_bit_q;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    data_n  = cmd_data;
                    par_n   = ~^cmd_data;
                    cnt_n   = '0;
                    state_n = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    state_n = S_RTS;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end

            S_RTS: begin
                // The RTS cycle itself is the first timed cycle, so the
                // count starts at 1 and ERROR lands TIMEOUT_CYCLES after entry.
                cnt_n     = CW'(1);
                bitn_n    = '0;
                dat_bit_n = 1'b0;
                state_n   = S_SHIFT;
            end

            S_SHIFT: begin
                // Timeout wins over a coincident falling edge.
                if (cnt_q == TO_LAST) begin
                    state_n = S_ERROR;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                    if (fall) begin
                        bitn_n = bitn_q + 1'b1;
                        if (bitn_q < 4'd8) begin
                            dat_bit_n = data_q[bitn_q[2:0]];
                        end else if (bitn_q == 4'd8) begin
                            dat_bit_n = par_q;
                        end else if (bitn_q == 4'd9) begin
                            dat_bit_n = 1'b1;
                        end else begin
                            state_n = dat_sync ? S_ERROR : S_WAIT_IDLE;
                        end
                    end
                end
            end

            S_WAIT_IDLE: begin
                if (cnt_q == TO_LAST) begin
                    state_n = S_ERROR;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                    if (clk_sync && dat_sync) begin
                        state_n = S_DONE;
                    end
                end
            end

            S_DONE:  state_n = S_IDLE;
            S_ERROR: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign tx_done   = (state == S_DONE);
    assign tx_error  = (state == S_ERROR);

    // Start bit goes out during the last inhibit cycle and is held through RTS.
    assign clk_low = (state == S_INHIBIT);
    assign dat_low = ((state == S_INHIBIT) && (cnt_q == INH_LAST)) ||
                     (state == S_RTS) ||
                     ((state == S_SHIFT) && !dat_bit_q);

    assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int H = 40;   // device clock half period in CLOCK_50 cycles

    logic       CLOCK_50  = 1'b0;
    logic       reset     = 1'b1;
    logic [7:0] cmd_data  = '0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready, busy, tx_done, tx_error;

    wire ps2_clk;
    wire ps2_dat;
    pullup (ps2_clk);
    pullup (ps2_dat);

    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .INHIBIT_CYCLES(5000),
        .TIMEOUT_CYCLES(2000)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .cmd_data (cmd_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .busy     (busy),
        .tx_done  (tx_done),
        .tx_error (tx_error),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (tx_done)  done_cnt++;
        if (tx_error) err_cnt++;
    end

    // Results of the most recent transfer
    logic [9:0] frame;
    int         inh_len, rts_at, end_at;
    logic       rts_found, end_seen, end_done;
    logic       busy_at, dat_at, busy_nxt, ready_nxt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Device model: waits for request-to-send, then clocks n_edges bits,
    // sampling the line on each rising edge; ack_low drives the ACK.
    task automatic dev_run(input int n_edges, input logic ack_low);
        rts_found = 1'b0;
        inh_len   = 0;
        frame     = '0;
        for (int i = 0; i < 8000 && !rts_found; i++) begin
            @(negedge CLOCK_50);
            if (ps2_clk === 1'b0) inh_len++;
            else if (ps2_dat === 1'b0 && inh_len > 0) begin
                rts_found = 1'b1;
                rts_at    = cyc;
            end
        end
        if (rts_found) begin
            repeat (H) @(negedge CLOCK_50);
            for (int e = 1; e <= n_edges; e++) begin
                if (e == 11) begin
                    dev_dat_low = ack_low;
                    repeat (5) @(negedge CLOCK_50);
                end
                dev_clk_low = 1'b1;
                repeat (H) @(negedge CLOCK_50);
                dev_clk_low = 1'b0;
                if (e <= 10) frame[e-1] = ps2_dat;
                repeat (H) @(negedge CLOCK_50);
            end
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_end();
        end_seen = 1'b0;
        for (int i = 0; i < 20000 && !end_seen; i++) begin
            @(negedge CLOCK_50);
            if (tx_done || tx_error) begin
                end_seen = 1'b1;
                end_at   = cyc;
                end_done = tx_done;
                busy_at  = busy;
                dat_at   = ps2_dat;
            end
        end
        if (end_seen) begin
            @(negedge CLOCK_50);
            busy_nxt  = busy;
            ready_nxt = cmd_ready;
        end
    endtask

    task automatic xfer(input int n_edges, input logic ack_low);
        fork
            dev_run(n_edges, ack_low);
            wait_end();
        join
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge CLOCK_50);
        cmd_data  = b;
        cmd_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        cmd_valid = 1'b0;
        check("busy_accept", busy, 1);
    endtask

    task automatic check_ok(input string tag, input logic [9:0] exp_frame, input int d0, input int e0);
        check({tag, "_rts"},     rts_found, 1);
        check({tag, "_end"},     end_seen, 1);
        check({tag, "_frame"},   frame, exp_frame);
        check({tag, "_isdone"},  end_done, 1);
        check({tag, "_busy_at"}, busy_at, 1);
        check({tag, "_busy_nx"}, busy_nxt, 0);
        check({tag, "_rdy_nx"},  ready_nxt, 1);
        check({tag, "_ndone"},   done_cnt - d0, 1);
        check({tag, "_nerr"},    err_cnt - e0, 0);
    endtask

    int d0, e0;

    initial begin
        // 1. reset
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_err", tx_error, 0);
        check("rst_clk", ps2_clk, 1);
        check("rst_dat", ps2_dat, 1);

        // 2. 0xED: data LSB first 1,0,1,1,0,1,1,1; parity 1; stop 1
        d0 = done_cnt; e0 = err_cnt;
        send(8'hED);
        xfer(11, 1'b1);
        check("ed_inhibit", inh_len, 5000);
        check_ok("ed", 10'h3ED, d0, e0);

        // 3. 0x07 (parity 0) with cmd_valid held and cmd_data changed
        //    mid-transfer; the held request then launches 0x00 (parity 1)
        d0 = done_cnt; e0 = err_cnt;
        @(negedge CLOCK_50);
        cmd_data  = 8'h07;
        cmd_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        cmd_data = 8'h00;
        xfer(11, 1'b1);
        check_ok("x07", 10'h207, d0, e0);
        d0 = done_cnt; e0 = err_cnt;
        @(posedge CLOCK_50);
        #1;
        cmd_valid = 1'b0;
        check("held_accept", busy, 1);
        xfer(11, 1'b1);
        check("x00_inhibit", inh_len, 5000);
        check_ok("x00", 10'h300, d0, e0);

        // 4. missing ACK: 0xA5, parity 1
        d0 = done_cnt; e0 = err_cnt;
        send(8'hA5);
        xfer(11, 1'b0);
        check("nak_end", end_seen, 1);
        check("nak_frame", frame, 10'h3A5);
        check("nak_isdone", end_done, 0);
        check("nak_rdy_nx", ready_nxt, 1);
        check("nak_ndone", done_cnt - d0, 0);
        check("nak_nerr", err_cnt - e0, 1);
        check("nak_clk", ps2_clk, 1);
        check("nak_dat", ps2_dat, 1);

        // 5. device never clocks: error 2000 cycles after RTS entry
        d0 = done_cnt; e0 = err_cnt;
        send(8'h12);
        xfer(0, 1'b1);
        check("to_rts", rts_found, 1);
        check("to_end", end_seen, 1);
        check("to_delay", end_at - rts_at, 2000);
        check("to_dat", dat_at, 1);
        check("to_nerr", err_cnt - e0, 1);
        check("to_ndone", done_cnt - d0, 0);

        // 6. reset after falling edge 5 of 0xFF, then 0xF4 (parity 0)
        d0 = done_cnt; e0 = err_cnt;
        send(8'hFF);
        dev_run(5, 1'b1);
        check("rr_rts", rts_found, 1);
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        check("rr_clk", ps2_clk, 1);
        check("rr_dat", ps2_dat, 1);
        check("rr_busy", busy, 0);
        check("rr_ready", cmd_ready, 1);
        @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (2500) @(negedge CLOCK_50);
        check("rr_ndone", done_cnt - d0, 0);
        check("rr_nerr", err_cnt - e0, 0);
        send(8'hF4);
        xfer(11, 1'b1);
        check_ok("xf4", 10'h2F4, d0, e0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
